// File: rtl/beep_gen.sv
// Buzzer driver: square-wave tone in ON/OFF bursts, started by a key pulse (N bursts) or held alarm level.
// Outputs registered, react at the sampling edge; no backpressure, requests arriving while busy are dropped.
module beep_gen #(
  parameter int HALF_PERIOD = 2,
  parameter int ON_CYCLES   = 100,
  parameter int OFF_CYCLES  = 100,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig_pulse,
  input  logic [3:0] repeat_n,
  input  logic       alarm_req,
  output logic       busy,
  output logic       beep_out,
  output logic       beep_done
);

  localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  generate
    if (HALF_PERIOD < 1 || ON_CYCLES < 1 || OFF_CYCLES < 1) begin : g_bad_len
      $error("beep_gen: HALF_PERIOD, ON_CYCLES and OFF_CYCLES must be >= 1");
    end
    if (longint'(ON_CYCLES) >= (longint'(1) << CNT_W) ||
        longint'(OFF_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_cnt
      $error("beep_gen: CNT_W too narrow for ON_CYCLES/OFF_CYCLES");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PH_W-1:0]  phase;
  logic [3:0]       remaining;
  logic             alarm_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      phase      <= '0;
      remaining  <= '0;
      alarm_mode <= 1'b0;
      busy       <= 1'b0;
      beep_out   <= 1'b0;
      beep_done  <= 1'b0;
    end else begin
      beep_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // Alarm wins over a coincident key pulse; that pulse is simply lost.
          if (alarm_req || trig_pulse) begin
            state      <= S_ON;
            busy       <= 1'b1;
            beep_out   <= 1'b1;
            cnt        <= '0;
            phase      <= '0;
            alarm_mode <= alarm_req;
            if (!alarm_req) remaining <= (repeat_n == 4'd0) ? 4'd1 : repeat_n;
          end
        end
        S_ON: begin
          if (cnt == ON_LAST) begin
            cnt      <= '0;
            phase    <= '0;
            beep_out <= 1'b0;
            if (!alarm_mode) remaining <= remaining - 4'd1;
            if (alarm_mode ? alarm_req : (remaining != 4'd1)) begin
              state <= S_OFF;
            end else begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              beep_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (phase == PH_LAST) begin
              phase    <= '0;
              beep_out <= ~beep_out;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        S_OFF: begin
          // A released alarm ends the gap immediately rather than waiting it out.
          if (alarm_mode && !alarm_req) begin
            state     <= S_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            beep_done <= 1'b1;
          end else if (cnt == OFF_LAST) begin
            state    <= S_ON;
            cnt      <= '0;
            phase    <= '0;
            beep_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          beep_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beep_gen.sv
// Randomized and directed bench for beep_gen against a timeline-based reference model.
module tb_beep_gen;
  localparam int HP   = 2;
  localparam int ONC  = 10;
  localparam int OFFC = 6;
  localparam int PER  = ONC + OFFC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig_pulse = 1'b0;
  logic [3:0] repeat_n = 4'd0;
  logic       alarm_req = 1'b0;
  logic       busy, beep_out, beep_done;

  beep_gen #(.HALF_PERIOD(HP), .ON_CYCLES(ONC), .OFF_CYCLES(OFFC), .CNT_W(17)) dut (
    .clk(clk), .rst(rst), .trig_pulse(trig_pulse), .repeat_n(repeat_n),
    .alarm_req(alarm_req), .busy(busy), .beep_out(beep_out), .beep_done(beep_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int busy_run = 0;
  int done_cnt = 0;

  // Reference model: position m_t inside the current sequence; bursts repeat every PER cycles.
  bit m_active = 1'b0;
  bit m_alarm  = 1'b0;
  bit m_done   = 1'b0;
  int m_t      = 0;
  int m_len    = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int exp_beep();
    int pos;
    pos = m_t % PER;
    return (m_active && pos < ONC && ((pos / HP) % 2 == 0)) ? 1 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    int  pos;
    int  r;
    bit  fin;
    if (rst) begin
      m_active = 1'b0;
      m_alarm  = 1'b0;
      m_done   = 1'b0;
      m_t      = 0;
      m_len    = 0;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (alarm_req) begin
          m_active = 1'b1;
          m_alarm  = 1'b1;
          m_t      = 0;
        end else if (trig_pulse) begin
          r        = (repeat_n == 4'd0) ? 1 : int'(repeat_n);
          m_active = 1'b1;
          m_alarm  = 1'b0;
          m_t      = 0;
          m_len    = r * ONC + (r - 1) * OFFC;
        end
      end else begin
        pos = m_t % PER;
        if (m_alarm) fin = (pos >= ONC - 1) && !alarm_req;
        else         fin = (m_t + 1 == m_len);
        if (fin) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_t = m_t + 1;
        end
      end
    end
  end

  task automatic tick(input string tag);
    @(negedge clk);
    check({tag, ".busy"}, int'(busy), int'(m_active));
    check({tag, ".beep"}, int'(beep_out), exp_beep());
    check({tag, ".done"}, int'(beep_done), int'(m_done));
    if (busy) busy_run++;
    if (beep_done) done_cnt++;
  endtask

  task automatic trig(input logic [3:0] r, input string tag);
    busy_run   = 0;
    done_cnt   = 0;
    trig_pulse = 1'b1;
    repeat_n   = r;
    tick(tag);
    trig_pulse = 1'b0;
  endtask

  initial begin
    tick("rst");
    tick("rst");
    rst = 1'b0;
    tick("idle");

    trig(4'd1, "single");
    repeat (15) tick("single");
    check("single_len", busy_run, 10);
    check("single_done", done_cnt, 1);

    trig(4'd3, "rep3");
    repeat (50) tick("rep3");
    check("rep3_len", busy_run, 42);
    check("rep3_done", done_cnt, 1);

    trig(4'd0, "rep0");
    repeat (4) tick("rep0");
    trig_pulse = 1'b1;
    repeat_n   = 4'd3;
    tick("rep0");
    trig_pulse = 1'b0;
    repeat (15) tick("rep0");
    check("rep0_len", busy_run, 10);

    busy_run  = 0;
    alarm_req = 1'b1;
    repeat (30) tick("alarm30");
    alarm_req = 1'b0;
    repeat (10) tick("alarm30");
    check("alarm30_len", busy_run, 30);

    busy_run  = 0;
    alarm_req = 1'b1;
    repeat (20) tick("alarm20");
    alarm_req = 1'b0;
    repeat (15) tick("alarm20");
    check("alarm20_len", busy_run, 26);

    alarm_req = 1'b1;
    trig(4'd5, "both");
    repeat (4) tick("both");
    alarm_req = 1'b0;
    repeat (30) tick("both");
    check("both_len", busy_run, 10);

    trig(4'd2, "arst");
    repeat (3) tick("arst");
    #1 rst = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_beep", int'(beep_out), 0);
    check("arst_done", int'(beep_done), 0);
    #1 rst = 1'b0;
    repeat (3) tick("arst_post");
    trig(4'd1, "arst_new");
    repeat (15) tick("arst_new");
    check("arst_new_len", busy_run, 10);
    check("arst_new_done", done_cnt, 1);

    repeat (3000) begin
      trig_pulse = ($urandom_range(0, 19) == 0);
      repeat_n   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) alarm_req = ~alarm_req;
      tick("rand");
    end
    trig_pulse = 1'b0;
    alarm_req  = 1'b0;
    repeat (300) tick("drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
